// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial A - B - Bin controller driving one external
// 1-bit full subtractor cell. Operands are latched on an accepted start,
// fed LSB-first one bit per clock, and the borrow recirculates through a
// register. The N-bit difference and final borrow appear WIDTH+1 cycles
// after acceptance, flagged by a one-cycle done pulse.
//
// Optional feature: define SERIAL_SUB_OVF_EN to add a registered signed
// overflow flag (ovf) that is updated together with diff.
//
// Handshake: start is a request that is only accepted while idle (busy=0,
// done=0); requests during RUN or DONE are dropped, never queued. done is a
// single-cycle strobe and diff/bout/ovf are valid from that cycle on and
// hold until the next operation's final bit edge.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             fs_a,
    output logic             fs_b,
    output logic             fs_bin,
    input  logic             fs_diff,
    input  logic             fs_bout
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             brw;
    logic [CW-1:0]    cnt;
    // Only the upper WIDTH-1 result bits need storage: the lowest collected
    // bit would be shifted out on the very edge that assembles the result.
    logic [WIDTH-2:0] res_sh;
    logic [WIDTH-1:0] res_n;
    logic             last_bit;
    logic             accept;

`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb;
    logic             b_msb;
`endif

    assign accept   = (state == IDLE) && start;
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign res_n    = {fs_diff, res_sh};

    // Cell operands come straight from the shift/borrow registers and are
    // forced to zero outside RUN so the cell sees a quiet input when idle.
    assign fs_a   = (state == RUN) & a_sh[0];
    assign fs_b   = (state == RUN) & b_sh[0];
    assign fs_bin = (state == RUN) & brw;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state and status decode.
    always_comb begin
        state_n = state;
        busy    = 1'b0;
        done    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Operand latch, bit-serial shifting and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            brw    <= 1'b0;
            cnt    <= '0;
            res_sh <= '0;
            diff   <= '0;
            bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh   <= a;
            b_sh   <= b;
            brw    <= bin;
            cnt    <= '0;
            res_sh <= '0;
`ifdef SERIAL_SUB_OVF_EN
            // Sign bits are kept aside because a_sh/b_sh shift them away.
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
        end else if (state == RUN) begin
            res_sh <= res_n[WIDTH-1:1];
            brw    <= fs_bout;
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            cnt    <= cnt + CW'(1);
            if (last_bit) begin
                diff <= res_n;
                bout <= fs_bout;
`ifdef SERIAL_SUB_OVF_EN
                ovf  <= (a_msb != b_msb) && (fs_diff != a_msb);
`endif
            end
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Bench for serial_sub_ctrl: a behavioural full subtractor cell closes the
// loop, and results are checked against plain integer arithmetic.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif
    logic         fs_a;
    logic         fs_b;
    logic         fs_bin;
    logic         fs_diff;
    logic         fs_bout;

    int n_tests;
    int n_fail;

    // Last completed result; diff/bout must hold this until the next finish.
    logic [W-1:0] last_diff;
    logic         last_bout;
`ifdef SERIAL_SUB_OVF_EN
    logic         last_ovf;
`endif

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .bin     (bin),
        .busy    (busy),
        .done    (done),
        .diff    (diff),
        .bout    (bout),
`ifdef SERIAL_SUB_OVF_EN
        .ovf     (ovf),
`endif
        .fs_a    (fs_a),
        .fs_b    (fs_b),
        .fs_bin  (fs_bin),
        .fs_diff (fs_diff),
        .fs_bout (fs_bout)
    );

    // Behavioural 1-bit full subtractor cell.
    assign fs_diff = fs_a ^ fs_b ^ fs_bin;
    assign fs_bout = (~fs_a & fs_b) | (~(fs_a ^ fs_b) & fs_bin);

    // Clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Borrow entering bit position k of A - B - Bin.
    function automatic logic borrow_in(input int ia, input int ib, input int ibin, input int k);
        int mask;
        mask = (1 << k) - 1;
        return ((ia & mask) < ((ib & mask) + ibin));
    endfunction

    // One full operation. Entered at a negedge with the DUT idle; leaves at
    // a negedge with the DUT idle again. With mid_start set, start is held
    // high during RUN while the operand inputs are scrambled.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tbin, input bit mid_start);
        int           ia;
        int           ib;
        int           ibin;
        int           r;
        logic [W-1:0] exp_d;
        logic         exp_bo;
        ia     = int'(ta);
        ib     = int'(tb_v);
        ibin   = int'(tbin);
        r      = ia - ib - ibin;
        exp_d  = W'(r);
        exp_bo = (ia < ib + ibin);
        start  = 1'b1;
        a      = ta;
        b      = tb_v;
        bin    = tbin;
        for (int k = 0; k < W; k++) begin
            @(negedge clk);
            check("run_busy", busy, 1'b1);
            check("run_done", done, 1'b0);
            check("fs_a", fs_a, ta[k]);
            check("fs_b", fs_b, tb_v[k]);
            check("fs_bin", fs_bin, borrow_in(ia, ib, ibin, k));
            if (k == 0) begin
                check("diff_hold", diff, last_diff);
                check("bout_hold", bout, last_bout);
            end
            start = mid_start;
            a     = W'($urandom_range(0, (1 << W) - 1));
            b     = W'($urandom_range(0, (1 << W) - 1));
            bin   = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("diff", diff, exp_d);
        check("bout", bout, exp_bo);
        check("fs_done", {fs_a, fs_b, fs_bin}, 3'b000);
`ifdef SERIAL_SUB_OVF_EN
        last_ovf = (ta[W-1] != tb_v[W-1]) && (exp_d[W-1] != ta[W-1]);
        check("ovf", ovf, last_ovf);
`endif
        start = 1'b0;
        @(negedge clk);
        check("idle_done", done, 1'b0);
        check("idle_busy", busy, 1'b0);
        check("fs_idle", {fs_a, fs_b, fs_bin}, 3'b000);
        last_diff = exp_d;
        last_bout = exp_bo;
    endtask

    initial begin
        int           pulses[$];
        logic [W-1:0] bb_d;
        logic         bb_bo;
        n_tests   = 0;
        n_fail    = 0;
        last_diff = '0;
        last_bout = 1'b0;
`ifdef SERIAL_SUB_OVF_EN
        last_ovf  = 1'b0;
`endif
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        bin   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_diff", diff, '0);
        check("rst_bout", bout, 1'b0);
        check("rst_fs", {fs_a, fs_b, fs_bin}, 3'b000);
`ifdef SERIAL_SUB_OVF_EN
        check("rst_ovf", ovf, 1'b0);
`endif
        rst = 1'b0;
        @(negedge clk);

        // Directed cases.
        run_op(8'h5A, 8'h23, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 1'b0, 1'b0);
        run_op(8'h00, 8'h00, 1'b1, 1'b0);
        run_op(8'hFF, 8'h01, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 1'b0, 1'b0);
        run_op(8'h05, 8'h03, 1'b0, 1'b0);
        run_op(8'h00, 8'hFF, 1'b1, 1'b0);
        run_op(8'hFF, 8'hFF, 1'b1, 1'b0);

        // Reset in the fourth RUN cycle aborts the operation.
        start = 1'b1;
        a     = 8'hC3;
        b     = 8'h3C;
        bin   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", busy, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_diff", diff, '0);
        check("abort_bout", bout, 1'b0);
        check("abort_fs", {fs_a, fs_b, fs_bin}, 3'b000);
        rst = 1'b0;
        last_diff = '0;
        last_bout = 1'b0;
        for (int c = 0; c < W + 2; c++) begin
            @(negedge clk);
            check("abort_no_done", done, 1'b0);
        end
        run_op(8'h5A, 8'h23, 1'b0, 1'b0);

        // Start held high: back-to-back operations.
        bb_d  = W'(int'(8'h9C) - int'(8'h47) - 1);
        bb_bo = 1'b0;
        start = 1'b1;
        a     = 8'h9C;
        b     = 8'h47;
        bin   = 1'b1;
        for (int c = 0; c < 3 * (W + 2); c++) begin
            @(negedge clk);
            if (!busy) begin
                check("bb_fs_quiet", {fs_a, fs_b, fs_bin}, 3'b000);
            end
            if (done) begin
                pulses.push_back(c);
                check("bb_diff", diff, bb_d);
                check("bb_bout", bout, bb_bo);
            end
        end
        start = 1'b0;
        check("bb_pulse_count", pulses.size(), 3);
        if (pulses.size() == 3) begin
            check("bb_first", pulses[0], W);
            check("bb_period1", pulses[1] - pulses[0], W + 2);
            check("bb_period2", pulses[2] - pulses[1], W + 2);
        end
        last_diff = bb_d;
        last_bout = bb_bo;
        @(negedge clk);
        check("bb_idle", busy, 1'b0);

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            run_op(W'($urandom_range(0, (1 << W) - 1)),
                   W'($urandom_range(0, (1 << W) - 1)),
                   1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
